wash_sequencer: RTL and testbench
=================================

# wash_sequencer

Downstream stage of the billing/price-confirmation block in the washing-machine controller. It accepts a one-cycle `start` pulse (the billing block's `next`) together with the selected wash mode and runs the timed phase sequence: fill, wash, drain, rinse, spin. It drives the valve and motor outputs and exports the remaining whole-cycle seconds for the 4-digit display. At the end it raises a completion pulse and a buzzer window.

## Interface
- `TICK_DIV`, 100_000_000: clk cycles per 1 s tick; must be ≥ 2.
- `FILL_S`, 3: FILL seconds.
- `WASH_S_S`, 6: WASH seconds, small.
- `WASH_S_M`, 9: WASH seconds, medium.
- `WASH_S_L`, 12: WASH seconds, large.
- `DRAIN_S`, 2: DRAIN seconds.
- `RINSE_S`, 4: RINSE seconds.
- `SPIN_S`, 5: SPIN seconds.
- `BUZZ_S`, 3: DONE/buzzer seconds.
- `clk`, in, 1: system clock.
- `rst`, in, 1: reset, asynchronous, active-low; clock `clk`.
- `start`, in, 1: one-cycle request from billing.
- `mode`, in, 2: 00 spin-only, 01 small, 10 medium, 11 large.
- `pause`, in, 1: one-cycle, already-debounced toggle request.
- `phase`, out, 3: current state encoding.
- `remain`, out, 8: seconds remaining in the whole cycle, binary.
- `valve_in`, out, 1: inlet valve.
- `valve_out`, out, 1: drain valve.
- `motor`, out, 2: 00 off, 01 wash speed, 10 spin speed.
- `busy`, out, 1: high in any state other than IDLE.
- `paused`, out, 1: pause active.
- `done`, out, 1: one-cycle pulse on entry to DONE.
- `buzzer`, out, 1: high throughout DONE.

## Operation
- States and `phase` encoding: IDLE=0, FILL=1, WASH=2, DRAIN=3, RINSE=4, SPIN=5, DONE=6.
- Sequence for modes 01/10/11: FILL → WASH → DRAIN → RINSE → SPIN → DONE → IDLE.
- Sequence for mode 00: SPIN → DONE → IDLE.
- Start acceptance: `start` is accepted only in IDLE.
  - `mode` is latched on acceptance; later `mode` changes are ignored until IDLE.
  - `start` in any other state is ignored.
- Initial `remain` on acceptance is the sum of the sequence durations (excluding BUZZ_S). With defaults: 00 → 5, 01 → 20, 10 → 23, 11 → 26.
- Per-phase counter is loaded with the phase duration on phase entry.
- On each tick, while not paused and not in IDLE/DONE:
  - phase counter decrements and `remain` decrements;
  - when the phase counter goes 1 → 0, the next phase is entered and its counter loaded on that same edge.
- DONE:
  - counts BUZZ_S ticks with `remain` held at 0, then returns to IDLE;
  - pause is ignored in DONE.
- Outputs decode from state, and are forced to all-off while `paused`:
  - FILL: `valve_in`.
  - WASH: `motor`=01.
  - DRAIN: `valve_out`.
  - RINSE: `valve_in` + `motor`=01.
  - SPIN: `valve_out` + `motor`=10.
  - IDLE/DONE: all off.
- Pause:
  - a `pause` pulse in FILL..SPIN toggles `paused`;
  - while paused, the prescaler, phase counter and `remain` are all frozen;
  - `pause` in IDLE/DONE is ignored;
  - `paused` clears on leaving SPIN.
- Arithmetic: all durations are 8-bit; the parameterised sum must be ≤ 255. No underflow is possible because `remain` is only decremented alongside a nonzero phase counter.

## Timing
- Reset values: `phase`=0, `remain`=0, `paused`=0, and `valve_in`, `valve_out`, `motor`, `busy`, `done`, `buzzer` all 0. Prescaler is cleared.
- Reset mid-run aborts immediately (asynchronously) to these values.
- Start latency: `start` sampled high in IDLE at edge k gives `phase`/`busy`/`remain` updated at edge k, visible in the following cycle. The prescaler is cleared at edge k, so the first tick occurs TICK_DIV cycles later.
- Tick: one-cycle strobe when the prescaler equals TICK_DIV−1. The prescaler wraps to 0 on the tick and holds while paused or in IDLE.
- Phase transitions and `done` are registered on the tick edge. `done` is high for exactly one cycle.
- Pause/tick coincidence: a `pause` in the same cycle as a tick still lets that tick take effect, and pausing starts from the next cycle. Resuming continues the prescaler from its frozen value.
- Start in the same cycle as the DONE→IDLE transition is ignored. Start is accepted from the first cycle in which IDLE is visible.

## Structure
- Shared header `wm_defs.vh` holds:
  - phase encodings;
  - mode encodings (shared with billing);
  - motor speed codes.
- Sub-module `tick_gen`: the prescaler with `en` and `clr` inputs and a `tick` output, parameter TICK_DIV. It is reusable by other timed blocks.
- The remaining logic (FSM, counters, output decode) stays in `wash_sequencer`.

## Test plan
Benches run with TICK_DIV=4.
- Reset: hold `rst`=0 with random inputs → all outputs 0, `phase`=0.
- mode=01 start pulse:
  - next cycle `phase`=1, `remain`=20, `valve_in`=1;
  - `phase`=2 after 12 clk;
  - `done` pulses 80 clk after start;
  - `buzzer` high for 12 clk, then IDLE.
- mode=00 start: `phase`=5, `remain`=5, `motor`=10, `valve_out`=1 → `done` after 20 clk.
- mode=11, pause mid-WASH at `remain`=20 held for 40 clk:
  - `remain` stays 20 and `motor`=00 throughout;
  - second pause resumes, and total run extends by exactly 40 clk.
- While busy, pulse `start` with `mode`=10 → no restart, latched mode unchanged, `remain` continues decrementing.
- Assert `rst`=0 during RINSE → outputs zero immediately; after release, `start` is accepted normally.

Source files
------------

// File: rtl/wash_sequencer_pkg.sv
// Shared definitions for the washing-machine controller: phase and mode
// encodings, motor speed codes and the state-to-actuator decode.
package wash_sequencer_pkg;

    // Phase encodings, also exported on the phase output.
    typedef enum logic [2:0] {
        PH_IDLE  = 3'd0,
        PH_FILL  = 3'd1,
        PH_WASH  = 3'd2,
        PH_DRAIN = 3'd3,
        PH_RINSE = 3'd4,
        PH_SPIN  = 3'd5,
        PH_DONE  = 3'd6
    } phase_e;

    // Wash mode encodings, shared with the billing block.
    typedef enum logic [1:0] {
        MODE_SPIN   = 2'b00,
        MODE_SMALL  = 2'b01,
        MODE_MEDIUM = 2'b10,
        MODE_LARGE  = 2'b11
    } mode_e;

    // Motor speed codes.
    localparam logic [1:0] MOTOR_OFF  = 2'b00;
    localparam logic [1:0] MOTOR_WASH = 2'b01;
    localparam logic [1:0] MOTOR_SPIN = 2'b10;

    // Actuator bundle driven by the sequencer.
    typedef struct packed {
        logic       valve_in;
        logic       valve_out;
        logic [1:0] motor;
    } drive_t;

    // Actuators per phase; everything is off while paused.
    function automatic drive_t decode_drive(input phase_e ph, input logic paused);
        drive_t d;
        d = '0;
        if (!paused) begin
            case (ph)
                PH_FILL:  d.valve_in = 1'b1;
                PH_WASH:  d.motor = MOTOR_WASH;
                PH_DRAIN: d.valve_out = 1'b1;
                PH_RINSE: begin
                    d.valve_in = 1'b1;
                    d.motor    = MOTOR_WASH;
                end
                PH_SPIN: begin
                    d.valve_out = 1'b1;
                    d.motor     = MOTOR_SPIN;
                end
                default: d = '0;
            endcase
        end
        return d;
    endfunction

endpackage

// File: rtl/wash_sequencer_tick_gen.sv
// Reusable prescaler: strobes tick for one cycle every TICK_DIV enabled
// cycles. The count holds while en is low and clr returns it to zero.
module tick_gen #(
    parameter int unsigned TICK_DIV = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned W = $clog2(TICK_DIV);
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == LAST);

    // Next count: clear has priority, wrap on tick, otherwise advance when enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Prescaler register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wash_sequencer.sv
// Timed wash phase sequencer: runs FILL..SPIN (or SPIN only) on a start
// pulse, counts whole-cycle seconds remaining, supports pause/resume and
// finishes with a done pulse and a buzzer window.
module wash_sequencer
    import wash_sequencer_pkg::*;
#(
    parameter int unsigned TICK_DIV = 100_000_000,
    parameter logic [7:0]  FILL_S   = 8'd3,
    parameter logic [7:0]  WASH_S_S = 8'd6,
    parameter logic [7:0]  WASH_S_M = 8'd9,
    parameter logic [7:0]  WASH_S_L = 8'd12,
    parameter logic [7:0]  DRAIN_S  = 8'd2,
    parameter logic [7:0]  RINSE_S  = 8'd4,
    parameter logic [7:0]  SPIN_S   = 8'd5,
    parameter logic [7:0]  BUZZ_S   = 8'd3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] mode,
    input  logic       pause,
    output logic [2:0] phase,
    output logic [7:0] remain,
    output logic       valve_in,
    output logic       valve_out,
    output logic [1:0] motor,
    output logic       busy,
    output logic       paused,
    output logic       done,
    output logic       buzzer
);

    phase_e     state_q, state_d;
    mode_e      mode_q, mode_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] remain_q, remain_d;
    logic       paused_q, paused_d;
    logic       done_q, done_d;
    logic       tick, tick_en, tick_clr;
    logic       active;
    drive_t     drv;

    function automatic logic [7:0] wash_secs(input mode_e m);
        case (m)
            MODE_SMALL:  return WASH_S_S;
            MODE_MEDIUM: return WASH_S_M;
            default:     return WASH_S_L;
        endcase
    endfunction

    // Timed phases that respond to pause and decrement remain.
    assign active  = (state_q == PH_FILL) || (state_q == PH_WASH) ||
                     (state_q == PH_DRAIN) || (state_q == PH_RINSE) ||
                     (state_q == PH_SPIN);
    // Prescaler runs in every non-idle state unless paused (DONE is never paused).
    assign tick_en = (state_q != PH_IDLE) && !paused_q;

    tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (tick_en),
        .clr  (tick_clr),
        .tick (tick)
    );

    // Next-state, counters, pause toggle and done strobe.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        cnt_d    = cnt_q;
        remain_d = remain_q;
        paused_d = paused_q;
        done_d   = 1'b0;
        tick_clr = 1'b0;

        // A pause coinciding with a tick still lets the tick act below.
        if (pause && active) begin
            paused_d = ~paused_q;
        end

        case (state_q)
            PH_IDLE: begin
                if (start) begin
                    mode_d   = mode_e'(mode);
                    tick_clr = 1'b1;
                    if (mode_e'(mode) == MODE_SPIN) begin
                        state_d  = PH_SPIN;
                        cnt_d    = SPIN_S;
                        remain_d = SPIN_S;
                    end else begin
                        state_d  = PH_FILL;
                        cnt_d    = FILL_S;
                        remain_d = FILL_S + wash_secs(mode_e'(mode)) + DRAIN_S +
                                   RINSE_S + SPIN_S;
                    end
                end
            end
            PH_FILL, PH_WASH, PH_DRAIN, PH_RINSE, PH_SPIN: begin
                if (tick) begin
                    remain_d = remain_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        case (state_q)
                            PH_FILL: begin
                                state_d = PH_WASH;
                                cnt_d   = wash_secs(mode_q);
                            end
                            PH_WASH: begin
                                state_d = PH_DRAIN;
                                cnt_d   = DRAIN_S;
                            end
                            PH_DRAIN: begin
                                state_d = PH_RINSE;
                                cnt_d   = RINSE_S;
                            end
                            PH_RINSE: begin
                                state_d = PH_SPIN;
                                cnt_d   = SPIN_S;
                            end
                            default: begin
                                // Leaving SPIN: pause state never carries into DONE.
                                state_d  = PH_DONE;
                                cnt_d    = BUZZ_S;
                                done_d   = 1'b1;
                                paused_d = 1'b0;
                            end
                        endcase
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            PH_DONE: begin
                if (tick) begin
                    if (cnt_q == 8'd1) begin
                        state_d = PH_IDLE;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            default: begin
                state_d  = PH_IDLE;
                cnt_d    = 8'd0;
                remain_d = 8'd0;
                paused_d = 1'b0;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= PH_IDLE;
            mode_q   <= MODE_SPIN;
            cnt_q    <= 8'd0;
            remain_q <= 8'd0;
            paused_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            cnt_q    <= cnt_d;
            remain_q <= remain_d;
            paused_q <= paused_d;
            done_q   <= done_d;
        end
    end

    // Output decode from registered state.
    always_comb begin
        drv = decode_drive(state_q, paused_q);
    end

    assign phase     = state_q;
    assign remain    = remain_q;
    assign valve_in  = drv.valve_in;
    assign valve_out = drv.valve_out;
    assign motor     = drv.motor;
    assign busy      = (state_q != PH_IDLE);
    assign paused    = paused_q;
    assign done      = done_q;
    assign buzzer    = (state_q == PH_DONE);

endmodule

// File: tb/tb_wash_sequencer.sv
// Bench for wash_sequencer with a fast prescaler. A driver issues start,
// mode and pause stimulus cycle by cycle and pushes the expected output
// vector for each cycle; a monitor pops and compares on the falling edge.
module tb_wash_sequencer;

    localparam int D    = 4;
    localparam int BUZZ = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] mode;
    logic       pause;
    logic [2:0] phase;
    logic [7:0] remain;
    logic       valve_in;
    logic       valve_out;
    logic [1:0] motor;
    logic       busy;
    logic       paused;
    logic       done;
    logic       buzzer;

    logic [18:0] dut_vec;
    logic [18:0] exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    wash_sequencer #(
        .TICK_DIV(D)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .pause     (pause),
        .phase     (phase),
        .remain    (remain),
        .valve_in  (valve_in),
        .valve_out (valve_out),
        .motor     (motor),
        .busy      (busy),
        .paused    (paused),
        .done      (done),
        .buzzer    (buzzer)
    );

    assign dut_vec = {phase, remain, valve_in, valve_out, motor, busy, paused, done, buzzer};

    // ---------------- reference model ----------------
    function automatic int wash_s(input int m);
        case (m)
            1:       return 6;
            2:       return 9;
            default: return 12;
        endcase
    endfunction

    function automatic int total_s(input int m);
        if (m == 0) return 5;
        return 3 + wash_s(m) + 2 + 4 + 5;
    endfunction

    // Phase number after s whole seconds of a run of mode m (s < total).
    function automatic int phase_at(input int m, input int s);
        int b;
        if (m == 0) return 5;
        b = 3;
        if (s < b) return 1;
        b = b + wash_s(m);
        if (s < b) return 2;
        b = b + 2;
        if (s < b) return 3;
        b = b + 4;
        if (s < b) return 4;
        return 5;
    endfunction

    function automatic logic [18:0] pack_out(input logic [2:0] ph, input logic [7:0] rem,
                                             input logic vi, input logic vo,
                                             input logic [1:0] mo, input logic b,
                                             input logic p, input logic d, input logic bz);
        return {ph, rem, vi, vo, mo, b, p, d, bz};
    endfunction

    // Expected outputs after a active (unpaused) clocks since acceptance.
    function automatic logic [18:0] expect_entry(input int m, input int a, input bit pz);
        int         s;
        int         t;
        int         ph;
        logic       vi;
        logic       vo;
        logic [1:0] mo;
        s  = a / D;
        t  = total_s(m);
        vi = 1'b0;
        vo = 1'b0;
        mo = 2'd0;
        if (s < t) begin
            ph = phase_at(m, s);
            if (!pz) begin
                case (ph)
                    1: vi = 1'b1;
                    2: mo = 2'd1;
                    3: vo = 1'b1;
                    4: begin vi = 1'b1; mo = 2'd1; end
                    default: begin vo = 1'b1; mo = 2'd2; end
                endcase
            end
            return pack_out(3'(ph), 8'(t - s), vi, vo, mo, 1'b1, pz, 1'b0, 1'b0);
        end
        return pack_out(3'd6, 8'd0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, (a == t * D), 1'b1);
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [18:0] e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (dut_vec !== e) begin
                n_fail++;
                $display("FAIL out_vec t=%0t got ph=%0d rem=%0d vi=%b vo=%b mo=%b busy=%b pz=%b done=%b bz=%b exp ph=%0d rem=%0d vi=%b vo=%b mo=%b busy=%b pz=%b done=%b bz=%b",
                         $time, dut_vec[18:16], dut_vec[15:8], dut_vec[7], dut_vec[6],
                         dut_vec[5:4], dut_vec[3], dut_vec[2], dut_vec[1], dut_vec[0],
                         e[18:16], e[15:8], e[7], e[6], e[5:4], e[3], e[2], e[1], e[0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check_zero(input string name);
        n_tests++;
        if (dut_vec !== 19'd0) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%h exp=0", name, $time, dut_vec);
        end
    endtask

    // One run of mode m. Pause pulses at cycles p_on/p_off after the start
    // cycle (0 = none); cut > 0 stops the run after that many cycles.
    // Spurious starts with random modes are thrown in while busy.
    task automatic run(input int m, input int p_on, input int p_off, input int cut);
        int a;
        int c;
        int t;
        int ph;
        bit pz;
        @(posedge clk);
        #1;
        start = 1'b1;
        mode  = 2'(m);
        pause = 1'b0;
        exp_q.push_back(19'd0);
        a  = 0;
        c  = 1;
        pz = 1'b0;
        t  = total_s(m);
        while ((a / D < t + BUZZ) && (cut == 0 || c < cut) && c < 3000) begin
            @(posedge clk);
            #1;
            exp_q.push_back(expect_entry(m, a, pz));
            mode  = 2'($urandom_range(0, 3));
            start = ($urandom_range(0, 7) == 0) || (a == (t + BUZZ) * D - 1);
            pause = (c == p_on) || (c == p_off);
            ph    = (a / D < t) ? phase_at(m, a / D) : 6;
            if (!pz) a++;
            if (pause && ph >= 1 && ph <= 5) pz = !pz;
            if (a / D >= t) pz = 1'b0;
            c++;
        end
        if (c >= 3000) begin
            n_tests++;
            n_fail++;
            $display("FAIL run_bound mode=%0d got=%0d cycles exp<3000", m, c);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            pause = 1'b0;
            mode  = 2'($urandom_range(0, 3));
            exp_q.push_back(19'd0);
        end
    endtask

    // ---------------- clock/reset and test sequence ----------------
    initial begin
        int p_on;
        rst   = 1'b0;
        start = 1'b0;
        mode  = 2'd0;
        pause = 1'b0;

        // Reset held with random inputs: everything stays zero.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            start = 1'($urandom_range(0, 1));
            mode  = 2'($urandom_range(0, 3));
            pause = 1'($urandom_range(0, 1));
            @(negedge clk);
            check_zero("reset_hold");
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        pause = 1'b0;
        rst   = 1'b1;
        idle_cycles(2);

        // Directed runs: small, spin-only, large with a 40-cycle pause in WASH.
        run(1, 0, 0, 0);
        run(0, 0, 0, 0);
        run(3, 26, 66, 0);

        // Reset during RINSE aborts immediately, then a normal run.
        run(1, 0, 0, 50);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_zero("reset_mid_run");
        repeat (3) @(posedge clk);
        #1;
        start = 1'b0;
        pause = 1'b0;
        check_zero("reset_after");
        rst = 1'b1;
        run(2, 0, 0, 0);

        // Randomized runs with a pause pair at random points.
        for (int k = 0; k < 8; k++) begin
            p_on = $urandom_range(1, 110);
            run($urandom_range(0, 3), p_on, p_on + $urandom_range(1, 30), 0);
        end
        idle_cycles(4);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_queue got=%0d left exp=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
